// File: rtl/multicycle_adder.sv
// Multi-cycle ripple adder/subtractor: processes CHUNK bits per clock, carrying
// between cycles through a register, with a start/busy/done handshake.
module multicycle_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] sum_r;
  logic             c_out_r;
  logic             overflow_r;
  logic             busy_r;
  logic             done_r;
  logic             accept_s;
  logic             last_s;
  logic [CHUNK:0]   chunk_full_s;
  logic             msb_cin_s;

  // Operands shift right each cycle, so the active chunk always sits at bit 0.
  assign chunk_full_s = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]}
                      + {{CHUNK{1'b0}}, carry_r};
  // Carry into the chunk's top bit, recovered from that bit's sum and inputs.
  assign msb_cin_s = chunk_full_s[CHUNK-1] ^ a_r[CHUNK-1] ^ b_r[CHUNK-1];

  assign accept_s = start && ((state_r == IDLE) || (state_r == DONE));
  assign last_s   = (state_r == RUN) && (cnt_r == LAST_CNT);

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (cnt_r == LAST_CNT) state_next_s = DONE;
        else                   state_next_s = RUN;
      end
      DONE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Datapath: load on accept, one chunk per RUN cycle; results shift in from the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      carry_r    <= 1'b0;
      cnt_r      <= {CW{1'b0}};
      sum_r      <= {WIDTH{1'b0}};
      c_out_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else if (accept_s) begin
      a_r     <= in_1;
      b_r     <= sub ? ~in_2 : in_2;
      carry_r <= sub ? 1'b1 : c_in;
      cnt_r   <= {CW{1'b0}};
    end else if (state_r == RUN) begin
      a_r     <= a_r >> CHUNK;
      b_r     <= b_r >> CHUNK;
      carry_r <= chunk_full_s[CHUNK];
      cnt_r   <= cnt_r + CW'(1);
      sum_r   <= (sum_r >> CHUNK) | (WIDTH'(chunk_full_s[CHUNK-1:0]) << (WIDTH - CHUNK));
      if (last_s) begin
        c_out_r    <= chunk_full_s[CHUNK];
        overflow_r <= msb_cin_s ^ chunk_full_s[CHUNK];
      end
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign sum      = sum_r;
  assign c_out    = c_out_r;
  assign overflow = overflow_r;

endmodule
